// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sampling mid-bit; define UART_RX_FRAME_ERR_EN to enable the stop-bit check on frm_err
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);
    localparam logic [11:0] HALF = 12'(BAUD_DIV / 2 - 1);
    localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);
    typedef enum logic {IDLE, RECEIVE} state_t;
    state_t      state, state_nx;
    logic        rx_m, rx_s;
    logic [11:0] baud_cnt, baud_nx;
    logic [3:0]  bit_cnt, bit_nx;
    logic [8:0]  sh, sh_nx;
    logic        start, shift, done;

    assign rx_data = sh[7:0];

    // two-flop synchroniser, preset to the idle-high line level
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rx_s, rx_m} <= 2'b11;
        else        {rx_s, rx_m} <= {rx_m, RX};

    // FSM state, baud/bit counters and the 9-bit frame shifter
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= 9'h1FF;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_cnt  <= bit_nx;
            sh       <= sh_nx;
        end

    // start detection, mid-bit sample strobe and end of frame after the stop sample
    always_comb begin
        start    = state == IDLE && !rx_s;
        shift    = state == RECEIVE && baud_cnt == '0;
        done     = state == RECEIVE && bit_cnt == 4'd10;
        state_nx = start ? RECEIVE : done ? IDLE : state;
        baud_nx  = start ? HALF : shift ? FULL : state == RECEIVE ? baud_cnt - 12'd1 : baud_cnt;
        bit_nx   = start ? '0 : shift ? bit_cnt + 4'd1 : bit_cnt;
        sh_nx    = shift ? {rx_s, sh[8:1]} : sh;
    end

    // rdy: set on frame completion (wins over clr_rdy), cleared by a new start or clr_rdy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdy <= 1'b0;
        else        rdy <= done | (rdy & ~start & ~clr_rdy);

`ifdef UART_RX_FRAME_ERR_EN
    // frm_err: captures a low stop sample alongside rdy, cleared like rdy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) frm_err <= 1'b0;
        else        frm_err <= done ? ~sh[8] : (start | clr_rdy) ? 1'b0 : frm_err;
`else
    assign frm_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, hand-written and random frame checks for uart_rx
module tb_uart_rx;
    localparam int DIV_A = 2604;
    localparam int DIV_B = 16;
    localparam int SET_B = 4 + DIV_B / 2 + 9 * DIV_B;
`ifdef UART_RX_FRAME_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic       pre;
        logic       set;
        logic       mid;
        logic [7:0] dat;
        logic       fe;
    } res_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       rxa = 1'b1, rxb = 1'b1, clra = 1'b0, clrb = 1'b0;
    logic [7:0] da, db;
    logic       rdya, rdyb, fea, feb;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    uart_rx #(.BAUD_DIV(DIV_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .RX(rxa), .clr_rdy(clra),
        .rx_data(da), .rdy(rdya), .frm_err(fea)
    );

    uart_rx #(.BAUD_DIV(DIV_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .RX(rxb), .clr_rdy(clrb),
        .rx_data(db), .rdy(rdyb), .frm_err(feb)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // reference: the byte is the weighted sum of frame bits 1..8 (LSB first on the line)
    function automatic logic [7:0] model_data(input logic [9:0] f);
        int v = 0;
        for (int i = 1; i <= 8; i++) v += int'(f[i]) * (1 << (i - 1));
        return 8'(v);
    endfunction

    // drives one full frame on dut_b starting at the current (post-edge) time, sampling outputs
    task automatic send_b(input logic [7:0] d, input logic stop, output res_t r);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        r = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        for (int n = 1; n <= 10 * DIV_B; n++) begin
            rxb = f[(n - 1) / DIV_B];
            @(posedge clk); #1;
            if (n == DIV_B) r.mid = rdyb;
            if (n == SET_B - 1) r.pre = rdyb;
            if (n == SET_B) begin
                r.set = rdyb;
                r.dat = db;
                r.fe  = feb;
            end
        end
    endtask

    task automatic pulse_clr();
        clrb = 1'b1;
        @(posedge clk); #1;
        clrb = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t       vt[6];
        res_t       r, r2;
        logic [9:0] fa;
        logic [9:0] fr;
        logic [7:0] v, rd;
        logic       rs;
        int         lat, hits, wait_n;

        vt[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vt[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vt[3] = '{8'h3C, 1'b0, 8'h3C, FE};
        vt[4] = '{8'h81, 1'b1, 8'h81, 1'b0};
        vt[5] = '{8'h5A, 1'b0, 8'h5A, FE};

        repeat (3) @(posedge clk); #1;
        chk("reset_rdy_a", rdya, 0);
        chk("reset_fe_a", fea, 0);
        chk("reset_data_a", da, 8'hFF);
        chk("reset_rdy_b", rdyb, 0);
        chk("reset_fe_b", feb, 0);
        chk("reset_data_b", db, 8'hFF);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // full-rate frame 0xA5: rdy edge count from the line falling
        fa  = {1'b1, 8'hA5, 1'b0};
        lat = 0;
        for (int n = 1; n <= 10 * DIV_A; n++) begin
            rxa = fa[(n - 1) / DIV_A];
            @(posedge clk); #1;
            if (rdya && lat == 0) lat = n;
        end
        checks++;
        if (lat < 24741 || lat > 24743) begin
            errors++;
            $display("FAIL a_latency: got %0d expected 24742 +/-1", lat);
        end
        chk("a_data", da, 8'hA5);
        chk("a_fe", fea, 0);

        // table vectors
        for (int i = 0; i < 6; i++) begin
            pulse_clr();
            send_b(vt[i].d, vt[i].stop, r);
            chk($sformatf("vec%0d_pre", i), r.pre, 0);
            chk($sformatf("vec%0d_rdy", i), r.set, 1);
            chk($sformatf("vec%0d_data", i), r.dat, vt[i].exp_d);
            chk($sformatf("vec%0d_fe", i), r.fe, vt[i].exp_fe);
            chk($sformatf("vec%0d_restart", i), rdyb, vt[i].stop);
            rxb = 1'b1;
            repeat (12 * DIV_B) @(posedge clk); #1;
        end

        // back-to-back 0x00 then 0xFF, no idle gap
        pulse_clr();
        send_b(8'h00, 1'b1, r);
        send_b(8'hFF, 1'b1, r2);
        chk("b2b_first_rdy", r.set, 1);
        chk("b2b_first_data", r.dat, 8'h00);
        chk("b2b_rdy_dropped", r2.mid, 0);
        chk("b2b_second_pre", r2.pre, 0);
        chk("b2b_second_rdy", r2.set, 1);
        chk("b2b_second_data", r2.dat, 8'hFF);

        // clr_rdy coinciding with set, then one cycle later
        fork
            send_b(8'h96, 1'b1, r);
            begin
                repeat (SET_B - 1) @(posedge clk); #1;
                chk("coin_pre", rdyb, 0);
                clrb = 1'b1;
                @(posedge clk); #1;
                chk("coin_set_wins", rdyb, 1);
                @(posedge clk); #1;
                clrb = 1'b0;
                chk("coin_late_clear", rdyb, 0);
                chk("coin_data_hold", db, 8'h96);
            end
        join

        // reset after four data bits of 0x5A, then a valid 0x81
        v   = 8'h5A;
        rxb = 1'b0;
        repeat (DIV_B) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rxb = v[i];
            repeat (DIV_B) @(posedge clk); #1;
        end
        rst_n = 1'b0;
        rxb   = 1'b1;
        #2;
        chk("abort_rdy", rdyb, 0);
        chk("abort_data", db, 8'hFF);
        chk("abort_fe", feb, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        hits = 0;
        for (int n = 0; n < 12 * DIV_B; n++) begin
            @(posedge clk); #1;
            if (rdyb) hits++;
        end
        chk("abort_no_rdy", hits, 0);
        send_b(8'h81, 1'b1, r);
        chk("after_abort_rdy", r.set, 1);
        chk("after_abort_data", r.dat, 8'h81);

        // sub-cycle glitch never reaches the sampler; a two-cycle low does start a frame
        pulse_clr();
        #1 rxb = 1'b0;
        #3 rxb = 1'b1;
        @(posedge clk); #1;
        hits = 0;
        for (int n = 0; n < 12 * DIV_B; n++) begin
            @(posedge clk); #1;
            if (rdyb) hits++;
        end
        chk("glitch_no_frame", hits, 0);
        rxb = 1'b0;
        repeat (2) @(posedge clk); #1;
        rxb = 1'b1;
        wait_n = 0;
        while (!rdyb && wait_n < 12 * DIV_B) begin
            @(posedge clk); #1;
            wait_n++;
        end
        chk("short_start_rdy", rdyb, 1);
        chk("short_start_data", db, 8'hFF);
        chk("short_start_fe", feb, 0);

        // random frames against the reference model
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            fr = {rs, rd, 1'b0};
            send_b(rd, rs, r);
            chk($sformatf("rnd%0d_pre", i), r.pre, 0);
            chk($sformatf("rnd%0d_rdy", i), r.set, 1);
            chk($sformatf("rnd%0d_data", i), r.dat, model_data(fr));
            chk($sformatf("rnd%0d_fe", i), r.fe, FE & ~fr[9]);
            rxb = 1'b1;
            if (rs) repeat ($urandom_range(0, 3)) @(posedge clk);
            else    repeat (12 * DIV_B) @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
